// File: rtl/writeback_queue.sv
// Writeback queue: buffers ALU/memory results and drains one per cycle into the
// register file write port, with a pending scoreboard and youngest-entry bypass.
module writeback_queue #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      mem_ready,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      hold,
  output logic                      we3,
  output logic [ADDR_W-1:0]         a3,
  output logic [DATA_W-1:0]         wd3,
  input  logic [ADDR_W-1:0]         rd_a1,
  input  logic [ADDR_W-1:0]         rd_a2,
  output logic                      byp1_hit,
  output logic                      byp2_hit,
  output logic [DATA_W-1:0]         byp1_data,
  output logic [DATA_W-1:0]         byp2_data,
  output logic [(2**ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            slots [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              deq;
  logic              enq;
  logic              space;
  entry_t            in_entry;

  // Flow control: memory path wins; a full queue still accepts while draining.
  always_comb begin
    empty     = (cnt == '0);
    full      = (cnt == CNT_W'(DEPTH));
    count     = cnt;
    deq       = !empty && !hold;
    space     = !full || deq;
    mem_ready = space;
    alu_ready = space && !mem_valid;
    enq       = space && (mem_valid || alu_valid);
    in_entry  = mem_valid ? '{addr: mem_addr, data: mem_data}
                          : '{addr: alu_addr, data: alu_data};
  end

  // Register file write port driven from the head entry.
  always_comb begin
    we3 = deq;
    a3  = '0;
    wd3 = '0;
    if (!empty) begin
      a3  = slots[rd_ptr].addr;
      wd3 = slots[rd_ptr].data;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    pending   = '0;
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < cnt) begin
        pending[slots[idx].addr] = 1'b1;
        if (slots[idx].addr == rd_a1) begin
          byp1_hit  = 1'b1;
          byp1_data = slots[idx].data;
        end
        if (slots[idx].addr == rd_a2) begin
          byp2_hit  = 1'b1;
          byp2_data = slots[idx].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Payload storage needs no reset; validity comes from pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && enq) slots[wr_ptr] <= in_entry;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst, mem_valid, alu_valid, hold;
  logic [ADDR_W-1:0] mem_addr, alu_addr, rd_a1, rd_a2;
  logic [DATA_W-1:0] mem_data, alu_data;
  logic mem_ready, alu_ready, we3, byp1_hit, byp2_hit, full, empty;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3, byp1_data, byp2_data;
  logic [NREG-1:0] pending;
  logic [$clog2(DEPTH):0] count;

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .hold(hold), .we3(we3), .a3(a3), .wd3(wd3),
    .rd_a1(rd_a1), .rd_a2(rd_a2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data),
    .pending(pending), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t model_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic mv, input logic [ADDR_W-1:0] ma,
                      input logic [DATA_W-1:0] md, input logic av,
                      input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic h, input logic [ADDR_W-1:0] r1,
                      input logic [ADDR_W-1:0] r2);
    int sz;
    logic e_deq, e_space, e_h1, e_h2;
    logic [DATA_W-1:0] e_d1, e_d2;
    logic [NREG-1:0] e_pend;
    @(negedge clk);
    rst = r; mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad; hold = h; rd_a1 = r1; rd_a2 = r2;
    #1;
    sz = model_q.size();
    e_deq = (sz > 0) && !h;
    e_space = (sz < DEPTH) || e_deq;
    e_pend = '0; e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
    foreach (model_q[i]) e_pend[model_q[i].a] = 1'b1;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!e_h1 && model_q[i].a == r1) begin e_h1 = 1'b1; e_d1 = model_q[i].d; end
      if (!e_h2 && model_q[i].a == r2) begin e_h2 = 1'b1; e_d2 = model_q[i].d; end
    end
    check("count", 32'(count), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("mem_ready", 32'(mem_ready), 32'(e_space));
    check("alu_ready", 32'(alu_ready), 32'(e_space && !mv));
    check("we3", 32'(we3), 32'(e_deq));
    check("a3", 32'(a3), (sz > 0) ? 32'(model_q[0].a) : 32'd0);
    check("wd3", 32'(wd3), (sz > 0) ? 32'(model_q[0].d) : 32'd0);
    check("pending", 32'(pending), 32'(e_pend));
    check("byp1_hit", 32'(byp1_hit), 32'(e_h1));
    check("byp1_data", 32'(byp1_data), 32'(e_d1));
    check("byp2_hit", 32'(byp2_hit), 32'(e_h2));
    check("byp2_data", 32'(byp2_data), 32'(e_d2));
    if (r) begin
      model_q.delete();
    end else begin
      if (e_deq) void'(model_q.pop_front());
      if (mv && e_space) model_q.push_back('{a: ma, d: md});
      else if (av && e_space) model_q.push_back('{a: aa, d: ad});
    end
  endtask

  task automatic idle(input logic h, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, h, r1, r2);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0; hold = 1'b0;
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0; rd_a1 = '0; rd_a2 = '0;
    repeat (2) @(posedge clk);
    // Reset cycle itself is checked through the model from here on.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(1'b0, 3'd0, 3'd1);

    // Single ALU write r2=5.
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd2, 19'd5, 1'b0, 3'd2, 3'd0);
    idle(1'b0, 3'd2, 3'd0);
    idle(1'b0, 3'd2, 3'd0);

    // Simultaneous mem r3=7 and alu r5=20: ALU retried next cycle.
    step(1'b0, 1'b1, 3'd3, 19'd7, 1'b1, 3'd5, 19'd20, 1'b0, 3'd3, 3'd5);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 19'd20, 1'b0, 3'd3, 3'd5);
    idle(1'b0, 3'd3, 3'd5);
    idle(1'b0, 3'd3, 3'd5);

    // Fill under hold, then full + drain + accept r6=77, then release.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 3'(i + 1), 19'(10 + i), 1'b1, 3'd1, 3'd4);
    step(1'b0, 1'b1, 3'd6, 19'd99, 1'b1, 3'd6, 19'd77, 1'b1, 3'd6, 3'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd6, 19'd77, 1'b0, 3'd6, 3'd1);
    for (int i = 0; i < 5; i++) idle(1'b0, 3'd6, 3'd2);

    // Two writes to r7 under hold: bypass must return the younger.
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 19'd40, 1'b1, 3'd7, 3'd0);
    step(1'b0, 1'b1, 3'd7, 19'd41, 1'b0, '0, '0, 1'b1, 3'd7, 3'd0);
    idle(1'b1, 3'd7, 3'd0);
    idle(1'b0, 3'd7, 3'd0);
    idle(1'b0, 3'd7, 3'd0);
    idle(1'b0, 3'd7, 3'd0);

    // Three entries under hold, then reset with inputs offered.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 3'(i), 19'(100 + i), 1'b0, '0, '0, 1'b1, 3'd0, 3'd1);
    step(1'b1, 1'b1, 3'd4, 19'd500, 1'b1, 3'd5, 19'd501, 1'b0, 3'd0, 3'd4);
    for (int i = 0; i < 3; i++) idle(1'b0, 3'd0, 3'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 45), ADDR_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 99) < 55), ADDR_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 99) < 35), ADDR_W'($urandom), ADDR_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers destination-register results from the ALU and memory paths and drains them one per cycle into the 8x19-bit register file write port (WE3/A3/WD3). It sits between the execute/memory stages and the register file. It exposes a per-register pending scoreboard and youngest-entry bypass lookups for the two read addresses, so decode can detect and forward in-flight writes.

## Interface
- DATA_W, 19, result / register width
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 4, queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  memory result offered
- mem_addr  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  memory result
- mem_ready  out  1  memory result accepted this cycle when mem_valid=1
- alu_valid  in  1  ALU result offered
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- hold  in  1  register-file write port unavailable; suppresses drain
- we3  out  1  write enable to register file
- a3  out  ADDR_W  write address to register file
- wd3  out  DATA_W  write data to register file
- rd_a1, rd_a2  in  ADDR_W  read addresses to look up
- byp1_hit, byp2_hit  out  1  queue holds a write to rd_a1 / rd_a2
- byp1_data, byp2_data  out  DATA_W  data of youngest matching entry, 0 when no hit
- pending  out  2**ADDR_W  bit r=1 iff any valid entry targets register r
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Circular FIFO: write pointer, read pointer, count; pointers wrap modulo DEPTH.
- Drain (deq) = !empty && !hold. we3=deq; a3/wd3 = head entry when !empty, else 0. Head removed at the edge where deq=1.
- Space this cycle: space = !full || deq (enqueue into a full queue allowed when draining in the same cycle).
- Arbitration, at most one enqueue per cycle, memory has priority: mem_ready=space; alu_ready=space && !mem_valid. Accepted source written at write pointer on the edge.
- count next = count + enq - deq; simultaneous enq and deq leave count unchanged.
- Drain order equals acceptance order; two queued writes to the same register both reach the register file, older first.
- pending: combinational OR over valid entries of one-hot(addr). Entry being drained this cycle still counts.
- Bypass: byp*_hit=1 iff any valid entry's addr equals rd_a*; byp*_data from the youngest such entry (closest to write pointer). Entries accepted this cycle are not visible until next cycle.
- All outputs are combinational from registered state plus inputs; no output register.

## Timing
- Reset (rst=1 at edge): pointers and count = 0. Following cycle: we3=0, a3=0, wd3=0, empty=1, full=0, count=0, pending=0, byp*_hit=0, byp*_data=0, mem_ready=1, alu_ready=!mem_valid.
- Reset mid-operation discards all queued entries; no write issued in the cycle after reset edge. Inputs presented in the reset cycle are not accepted.
- Latency: result accepted at edge N is on we3/a3/wd3 in cycle N+1 if queue was otherwise empty and hold=0; register file updates at edge N+1.
- hold=1 freezes the head; we3=0; entries keep accumulating until full.
- Full and hold=1: both readys 0. Full and hold=0: accept one, drain one.
- Throughput: one result in and one write out per cycle sustained.

## Test plan
- Single ALU write r2=5, hold=0, empty queue -> alu_ready=1; next cycle we3=1, a3=2, wd3=5, pending[2]=1; cycle after empty=1, pending=0.
- mem_valid and alu_valid same cycle (mem r3=7, alu r5=20) -> mem_ready=1, alu_ready=0; ALU held and accepted next cycle; writes r3=7 then r5=20 on consecutive cycles.
- hold=1, enqueue r1..r4 with 10,11,12,13 -> count=4, full=1, both readys 0; release hold -> writes drain in order, one per cycle, count 4,3,2,1,0.
- Full queue, hold=0, alu r6=77 -> accepted same cycle head drains; count stays 4; pointers wrap; r6=77 written last.
- hold=1, queue r7=40 then r7=41, rd_a1=7, rd_a2=0 -> byp1_hit=1, byp1_data=41, byp2_hit=0, byp2_data=0; pending=8'h80.
- Three entries queued under hold, assert rst one cycle -> next cycle count=0, empty=1, we3=0, pending=0; no queued write ever appears.
